// File: rtl/r4_butter_seq.sv
// Handshaked radix-4 DFT butterfly: captures one complex quad, emits its four bins serially at full precision.
// Optional macro R4_BITREV_EN selects bit-reversed emit order (0,2,1,3); default is natural order.
module r4_butter_seq #(
    parameter  int DATA_W = 4,
    localparam int OUT_W  = DATA_W + 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_inv,
    input  logic signed [DATA_W-1:0] xr0,
    input  logic signed [DATA_W-1:0] xi0,
    input  logic signed [DATA_W-1:0] xr1,
    input  logic signed [DATA_W-1:0] xi1,
    input  logic signed [DATA_W-1:0] xr2,
    input  logic signed [DATA_W-1:0] xi2,
    input  logic signed [DATA_W-1:0] xr3,
    input  logic signed [DATA_W-1:0] xi3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_re,
    output logic signed [OUT_W-1:0]  out_im,
    output logic [1:0]               out_bin,
    output logic                     out_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                   state;
    logic [1:0]               k;
    logic                     inv_q;
    logic signed [DATA_W-1:0] sr_q [4];
    logic signed [DATA_W-1:0] si_q [4];

    logic                     accept;
    logic                     src_inv;
    logic [1:0]               src_k;
    logic [1:0]               bin_sel;
    logic [1:0]               eq_sel;
    logic signed [DATA_W-1:0] src_r [4];
    logic signed [DATA_W-1:0] src_i [4];
    logic signed [OUT_W-1:0]  er [4];
    logic signed [OUT_W-1:0]  ei [4];
    logic signed [OUT_W-1:0]  bin_re;
    logic signed [OUT_W-1:0]  bin_im;

    function automatic logic [1:0] emit_order(input logic [1:0] idx);
`ifdef R4_BITREV_EN
        return {idx[0], idx[1]};
`else
        return idx;
`endif
    endfunction

    assign in_ready = (state == IDLE) | (out_valid & out_ready & out_last);
    assign accept   = in_valid & in_ready & ~clr;

    // On acceptance the first bin comes straight from the ports; afterwards from the stored quad.
    always_comb begin
        src_r[0] = accept ? xr0 : sr_q[0];
        src_i[0] = accept ? xi0 : si_q[0];
        src_r[1] = accept ? xr1 : sr_q[1];
        src_i[1] = accept ? xi1 : si_q[1];
        src_r[2] = accept ? xr2 : sr_q[2];
        src_i[2] = accept ? xi2 : si_q[2];
        src_r[3] = accept ? xr3 : sr_q[3];
        src_i[3] = accept ? xi3 : si_q[3];
        src_inv  = accept ? in_inv : inv_q;
        src_k    = accept ? 2'd0 : k + 2'd1;
        bin_sel  = emit_order(src_k);
        // Inverse transform swaps the X1 and X3 equations.
        eq_sel   = {bin_sel[1] ^ (src_inv & bin_sel[0]), bin_sel[0]};
        for (int n = 0; n < 4; n++) begin
            er[n] = OUT_W'(src_r[n]);
            ei[n] = OUT_W'(src_i[n]);
        end
        case (eq_sel)
            2'd0: begin
                bin_re = er[0] + er[1] + er[2] + er[3];
                bin_im = ei[0] + ei[1] + ei[2] + ei[3];
            end
            2'd1: begin
                bin_re = er[0] + ei[1] - er[2] - ei[3];
                bin_im = ei[0] - er[1] - ei[2] + er[3];
            end
            2'd2: begin
                bin_re = er[0] - er[1] + er[2] - er[3];
                bin_im = ei[0] - ei[1] + ei[2] - ei[3];
            end
            default: begin
                bin_re = er[0] - ei[1] - er[2] + ei[3];
                bin_im = ei[0] + er[1] - ei[2] - er[3];
            end
        endcase
    end

    // NOTE: the sample store is not reset; it is only read after a capture has written it.
    always_ff @(posedge CLK) begin
        if (accept) begin
            sr_q  <= '{xr0, xr1, xr2, xr3};
            si_q  <= '{xi0, xi1, xi2, xi3};
            inv_q <= in_inv;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            k         <= 2'd0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_bin   <= 2'd0;
            out_last  <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            k         <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= EMIT;
            k         <= 2'd0;
            out_valid <= 1'b1;
            out_re    <= bin_re;
            out_im    <= bin_im;
            out_bin   <= bin_sel;
            out_last  <= 1'b0;
        end else if (state == EMIT && out_ready) begin
            if (k == 2'd3) begin
                state     <= IDLE;
                k         <= 2'd0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                k         <= src_k;
                out_re    <= bin_re;
                out_im    <= bin_im;
                out_bin   <= bin_sel;
                out_last  <= (src_k == 2'd3);
            end
        end
    end

endmodule

// File: tb/tb_r4_butter_seq.sv
// Directed self-checking bench for r4_butter_seq (DATA_W=4); honours R4_BITREV_EN for the expected emit order.
module tb_r4_butter_seq;

    logic              CLK, RST, clr, in_valid, in_ready, in_inv, out_valid, out_ready, out_last;
    logic signed [3:0] xr0, xi0, xr1, xi1, xr2, xi2, xr3, xi3;
    logic signed [5:0] out_re, out_im;
    logic [1:0]        out_bin;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int xr [4];
        int xi [4];
        bit inv;
        int er [4];
        int ei [4];
    } vec_t;

    vec_t vecs [6];

    r4_butter_seq #(.DATA_W(4)) dut (
        .CLK(CLK), .RST(RST), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .xr0(xr0), .xi0(xi0), .xr1(xr1), .xi1(xi1),
        .xr2(xr2), .xi2(xi2), .xr3(xr3), .xi3(xi3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_bin(out_bin), .out_last(out_last)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // True bin index of the j-th emitted bin.
    function automatic int ord(input int j);
`ifdef R4_BITREV_EN
        return ((j & 1) << 1) | ((j >> 1) & 1);
`else
        return j;
`endif
    endfunction

    task automatic drive_quad(input int vi);
        xr0 = 4'(vecs[vi].xr[0]); xi0 = 4'(vecs[vi].xi[0]);
        xr1 = 4'(vecs[vi].xr[1]); xi1 = 4'(vecs[vi].xi[1]);
        xr2 = 4'(vecs[vi].xr[2]); xi2 = 4'(vecs[vi].xi[2]);
        xr3 = 4'(vecs[vi].xr[3]); xi3 = 4'(vecs[vi].xi[3]);
        in_inv = vecs[vi].inv;
    endtask

    task automatic check_bin(input string tag, input int vi, input int j);
        int b;
        b = ord(j);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_bin"},   32'(out_bin), b);
        check({tag, "_re"},    out_re, vecs[vi].er[b]);
        check({tag, "_im"},    out_im, vecs[vi].ei[b]);
        check({tag, "_last"},  32'(out_last), (j == 3) ? 1 : 0);
    endtask

    initial begin
        vecs[0] = '{xr:'{1, 2, 3, 4},     xi:'{0, 0, 0, 0},     inv:1'b0,
                    er:'{10, -2, -2, -2}, ei:'{0, 2, 0, -2}};
        vecs[1] = '{xr:'{1, 2, 3, 4},     xi:'{0, 0, 0, 0},     inv:1'b1,
                    er:'{10, -2, -2, -2}, ei:'{0, -2, 0, 2}};
        vecs[2] = '{xr:'{-8, -8, -8, -8}, xi:'{-8, -8, -8, -8}, inv:1'b0,
                    er:'{-32, 0, 0, 0},   ei:'{-32, 0, 0, 0}};
        vecs[3] = '{xr:'{7, -8, -8, -8},  xi:'{7, -8, -8, -8},  inv:1'b0,
                    er:'{-17, 15, 15, 15}, ei:'{-17, 15, 15, 15}};
        vecs[4] = '{xr:'{1, 3, -4, 0},    xi:'{2, -1, 5, -3},   inv:1'b0,
                    er:'{0, 7, -6, 3},    ei:'{3, -6, 11, 0}};
        vecs[5] = '{xr:'{1, 3, -4, 0},    xi:'{2, -1, 5, -3},   inv:1'b1,
                    er:'{0, 3, -6, 7},    ei:'{3, 0, 11, -6}};

        RST = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_quad(0);
        #12;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_re",    out_re, 0);
        check("rst_im",    out_im, 0);
        check("rst_bin",   32'(out_bin), 0);
        check("rst_last",  32'(out_last), 0);
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_valid_after", 32'(out_valid), 0);

        // Table-driven: one quad per vector, continuous out_ready.
        out_ready = 1'b1;
        for (int vi = 0; vi < 6; vi++) begin
            @(posedge CLK); #1;
            drive_quad(vi);
            in_valid = 1'b1;
            @(negedge CLK);
            check("vec_in_ready_idle", 32'(in_ready), 1);
            @(posedge CLK); #1;
            in_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                @(negedge CLK);
                check_bin($sformatf("vec%0d_b%0d", vi, j), vi, j);
                check("vec_in_ready", 32'(in_ready), (j == 3) ? 1 : 0);
                @(posedge CLK); #1;
            end
            @(negedge CLK);
            check("vec_idle_valid", 32'(out_valid), 0);
        end

        // Backpressure with a second quad waiting on in_valid.
        begin
            int j;
            j = 0;
            @(posedge CLK); #1;
            drive_quad(0);
            in_valid  = 1'b1;
            out_ready = 1'b0;
            @(posedge CLK); #1;
            drive_quad(4);
            for (int cyc = 0; cyc < 24 && j < 8; cyc++) begin
                out_ready = (cyc % 2) == 1;
                @(negedge CLK);
                check_bin($sformatf("bp_j%0d_c%0d", j, cyc), (j < 4) ? 0 : 4, j % 4);
                check("bp_in_ready", 32'(in_ready), (out_ready && (j % 4) == 3) ? 1 : 0);
                @(posedge CLK);
                if (out_ready) j++;
                #1;
                if (j >= 4) in_valid = 1'b0;
            end
            check("bp_done", j, 8);
            @(negedge CLK);
            check("bp_idle_valid", 32'(out_valid), 0);
        end

        // Asynchronous reset while the second bin is presented.
        out_ready = 1'b1;
        @(posedge CLK); #1;
        drive_quad(0);
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("ar_bin_before", 32'(out_bin), ord(1));
        #1 RST = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_re",    out_re, 0);
        check("ar_im",    out_im, 0);
        check("ar_bin",   32'(out_bin), 0);
        check("ar_last",  32'(out_last), 0);
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK);
        check("ar_in_ready", 32'(in_ready), 1);
        check("ar_valid_after", 32'(out_valid), 0);

        // clr during the third bin, then held for a cycle while a quad is offered.
        @(posedge CLK); #1;
        drive_quad(0);
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("clr_bin_before", 32'(out_bin), ord(2));
        clr = 1'b1;
        @(posedge CLK); #1;
        drive_quad(4);
        in_valid = 1'b1;
        @(negedge CLK);
        check("clr_valid", 32'(out_valid), 0);
        check("clr_in_ready", 32'(in_ready), 1);
        @(posedge CLK); #1;
        clr = 1'b0;
        @(negedge CLK);
        check("clr_not_accepted", 32'(out_valid), 0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        check_bin("clr_restart", 4, 0);
        for (int j = 1; j < 4; j++) begin
            @(negedge CLK);
            check_bin($sformatf("clr_drain_b%0d", j), 4, j);
        end
        @(negedge CLK);
        check("clr_final_idle", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
